// File: rtl/tbr_word_sink_if.sv
// tbr_word_sink_if
//   Groups the I/O-bus control signals and the word-stream handshake of
//   tbr_word_sink. The 8-bit data bus is bidirectional and is a plain
//   inout port on the block itself, not a member of this interface.
//
//   Signals:
//     addr      16  I/O address from the bus master
//     ior_       1  read strobe, active low
//     iow_       1  write strobe, active low
//     out_word  16  FIFO head word {high byte, low byte}
//     out_valid  1  FIFO is non-empty
//     out_ready  1  consumer accepts out_word
//
//   Handshake: a word transfers on every rising clock edge where
//   out_valid && out_ready. While out_valid=1 and out_ready=0, out_word
//   holds stable. out_valid never depends on out_ready.
//
//   Modports:
//     master - the bus master and the downstream consumer
//     slave  - tbr_word_sink
interface tbr_word_sink_if;
    logic [15:0] addr;
    logic        ior_;
    logic        iow_;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output addr, ior_, iow_, out_ready,
        input  out_word, out_valid
    );

    modport slave (
        input  addr, ior_, iow_, out_ready,
        output out_word, out_valid
    );
endinterface

// File: rtl/tbr_word_sink.sv
// tbr_word_sink
//   Bus-slave sink for the transmit buffer register (TBR). The bus master
//   writes a 16-bit product as two byte writes to BASE, high byte first.
//   This block pairs those bytes into words, buffers the words in a
//   DEPTH-entry FIFO and presents them on a valid/ready stream. A read-only
//   status register (TSR) at BASE+1 reports the FIFO state and a sticky
//   overflow flag. A TSR read event clears the overflow flag.
//
//   Ports:
//     clock        system clock
//     reset        synchronous, active-high reset
//     bus          tbr_word_sink_if.slave: addr, ior_, iow_, out_word,
//                  out_valid, out_ready
//     data         8-bit I/O data bus; driven only during a TSR read
//     dbg_phase_o  byte-pairing state (1 = high byte held, waiting for low)
//
//   TSR layout: {1'b0, count[2:0], 1'b0, overflow, empty, not_full}.
//   count saturates at 7.
module tbr_word_sink #(
    parameter logic [15:0] BASE  = 16'h0140,
    parameter int          DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    tbr_word_sink_if.slave  bus,
    inout  wire  [7:0]      data,
    output logic            dbg_phase_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic            iow_q, ior_q;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;

    logic            wr_ev, rd_ev, tsr_sel;
    logic            push, do_push, drop, pop, empty, full;
    logic [15:0]     push_word;
    logic [2:0]      cnt3;
    logic [7:0]      tsr;

    // Detect falling edges of the strobes. A strobe held low for several
    // cycles therefore produces only one event.
    assign wr_ev   = !bus.iow_ && iow_q && (bus.addr == BASE);
    assign rd_ev   = !bus.ior_ && ior_q && (bus.addr == BASE + 16'd1);
    assign tsr_sel = !bus.ior_ && (bus.addr == BASE + 16'd1);

    // Byte-pairing state machine.
    always_comb begin
        phase_d   = phase_q;
        hi_d      = hi_q;
        push      = 1'b0;
        push_word = 16'h0000;
        case (phase_q)
            PH_HI: begin
                if (wr_ev) begin
                    hi_d    = data;
                    phase_d = PH_LO;
                end
            end
            PH_LO: begin
                if (wr_ev) begin
                    push      = 1'b1;
                    push_word = {hi_q, data};
                    phase_d   = PH_HI;
                end
            end
            default: phase_d = PH_HI;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // pop depends only on registered state, so a word pushed into an empty
    // FIFO cannot leave before the following edge.
    assign pop     = !empty && bus.out_ready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= PH_HI;
            hi_q     <= 8'h00;
            iow_q    <= 1'b1;
            ior_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            iow_q   <= bus.iow_;
            ior_q   <= bus.ior_;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Setting the overflow flag takes priority over a read-clear on
            // the same edge.
            if (drop)       ovf_q <= 1'b1;
            else if (rd_ev) ovf_q <= 1'b0;
        end
    end

    // Storage needs no reset: out_word is forced to zero while empty.
    always_ff @(posedge clock) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.out_valid = !empty;
    assign bus.out_word  = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign dbg_phase_o   = (phase_q == PH_LO);

    generate
        if (CW > 3) begin : g_cnt_sat
            assign cnt3 = (count_q > CW'(7)) ? 3'd7 : count_q[2:0];
        end else begin : g_cnt_narrow
            assign cnt3 = 3'(count_q);
        end
    endgenerate

    assign tsr  = {1'b0, cnt3, 1'b0, ovf_q, empty, !full};
    assign data = tsr_sel ? tsr : 8'hzz;
endmodule

// File: tb/tb_tbr_word_sink.sv
module tb_tbr_word_sink;
  localparam logic [15:0] BASE  = 16'h0140;
  localparam int          DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tbr_word_sink_if bus ();
  wire  [7:0] data;
  logic [7:0] tb_dout = 8'h00;
  logic       tb_oe   = 1'b0;
  logic       dbg_phase;

  assign data = tb_oe ? tb_dout : 8'hzz;
  // A released bus reads back as all ones.
  pullup pu_data (data);

  tbr_word_sink #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .data        (data),
    .dbg_phase_o (dbg_phase)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is a queue of words. A pending high byte is a flag plus a byte.
  // Strobe events come from remembering the previous strobe level.
  logic [15:0] exp_q[$];
  logic        m_have_hi = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  logic        m_ovf = 1'b0;
  logic        m_prev_iow = 1'b1;
  logic        m_prev_ior = 1'b1;
  logic        seen_reset = 1'b0;

  function automatic logic [7:0] model_tsr();
    int n;
    n = exp_q.size();
    return {1'b0, 3'((n > 7) ? 7 : n), 1'b0, m_ovf, (n == 0), (n < DEPTH)};
  endfunction

  // Inputs change 2 ns after each rising edge. At edge+1 they still hold the
  // values the DUT just sampled.
  initial forever begin
    @(posedge clock);
    #1;
    if (reset) begin
      exp_q.delete();
      m_have_hi  = 1'b0;
      m_ovf      = 1'b0;
      m_prev_iow = 1'b1;
      m_prev_ior = 1'b1;
      seen_reset = 1'b1;
    end else begin
      bit wr_ev, rd_ev, do_pop, push, set_ovf;
      logic [15:0] w;
      int n_before;
      wr_ev    = !bus.iow_ && m_prev_iow && bus.addr == BASE;
      rd_ev    = !bus.ior_ && m_prev_ior && bus.addr == BASE + 16'd1;
      n_before = exp_q.size();
      do_pop   = (n_before > 0) && bus.out_ready;
      push     = 1'b0;
      set_ovf  = 1'b0;
      w        = 16'h0000;
      if (wr_ev) begin
        if (!m_have_hi) begin
          m_have_hi = 1'b1;
          m_hi      = data;
        end else begin
          m_have_hi = 1'b0;
          push      = 1'b1;
          w         = {m_hi, data};
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (push) begin
        if (n_before < DEPTH || do_pop) exp_q.push_back(w);
        else set_ovf = 1'b1;
      end
      if (set_ovf)    m_ovf = 1'b1;
      else if (rd_ev) m_ovf = 1'b0;
      m_prev_iow = bus.iow_;
      m_prev_ior = bus.ior_;
    end
    // compare DUT against model every cycle
    if (seen_reset) begin
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("out_word", 32'(bus.out_word), 32'((exp_q.size() != 0) ? exp_q[0] : 16'h0000));
      if (!tb_oe) begin
        if (!bus.ior_ && bus.addr == BASE + 16'd1)
          check("tsr_bus", 32'(data), 32'(model_tsr()));
        else
          check("bus_released", 32'(data), 32'hFF);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input int hold);
    bus.addr = a;
    tb_dout  = d;
    tb_oe    = 1'b1;
    bus.iow_ = 1'b0;
    repeat (hold) step();
    bus.iow_ = 1'b1;
    tb_oe    = 1'b0;
    step();
  endtask

  task automatic wr_word(input logic [15:0] w);
    wr_byte(BASE, w[15:8], 1);
    wr_byte(BASE, w[7:0], 1);
  endtask

  task automatic rd_tsr(input string name, input logic [7:0] exp);
    bus.addr = BASE + 16'd1;
    bus.ior_ = 1'b0;
    #1;
    check(name, 32'(data), 32'(exp));
    step();
    bus.ior_ = 1'b1;
    step();
  endtask

  task automatic pop_expect(input string name, input logic [15:0] exp);
    check({name, "_valid"}, 32'(bus.out_valid), 32'h1);
    check(name, 32'(bus.out_word), 32'(exp));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.addr      = 16'h0000;
    bus.ior_      = 1'b1;
    bus.iow_      = 1'b1;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_word", 32'(bus.out_word), 32'h0);
    check("rst_bus_z", 32'(data), 32'hFF);
    rd_tsr("rst_tsr", 8'h03);

    // First word
    wr_word(16'h1234);
    check("w1_valid", 32'(bus.out_valid), 32'h1);
    check("w1_word", 32'(bus.out_word), 32'h1234);
    rd_tsr("w1_tsr", 8'h11);
    pop_expect("w1_pop", 16'h1234);

    // Fill the FIFO and overflow it
    for (int i = 1; i <= 4; i++) wr_word(16'(i));
    rd_tsr("full_tsr", 8'h40);
    wr_word(16'hBEEF);
    rd_tsr("ovf_tsr", 8'h44);
    rd_tsr("ovf_cleared_tsr", 8'h40);
    for (int i = 1; i <= 4; i++) pop_expect("drain", 16'(i));
    check("drain_empty", 32'(bus.out_valid), 32'h0);

    // Push on full with a simultaneous pop
    for (int i = 0; i < 4; i++) wr_word(16'h0011 + 16'(i));
    wr_byte(BASE, 8'h55, 1);
    bus.addr      = BASE;
    tb_dout       = 8'h55;
    tb_oe         = 1'b1;
    bus.iow_      = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.iow_      = 1'b1;
    tb_oe         = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rd_tsr("full_pop_tsr", 8'h40);
    pop_expect("wrap0", 16'h0012);
    pop_expect("wrap1", 16'h0013);
    pop_expect("wrap2", 16'h0014);
    pop_expect("wrap3", 16'h5555);
    check("wrap_empty", 32'(bus.out_valid), 32'h0);

    // Long write strobe counts once
    wr_byte(BASE, 8'hAA, 3);
    wr_byte(BASE, 8'hBB, 1);
    rd_tsr("hold_tsr", 8'h11);
    pop_expect("hold_word", 16'hAABB);

    // Foreign addresses are ignored
    wr_byte(BASE, 8'hC0, 1);
    wr_byte(16'h0141, 8'h99, 1);
    wr_byte(16'h0120, 8'h98, 1);
    check("foreign_none", 32'(bus.out_valid), 32'h0);
    wr_byte(BASE, 8'hDE, 1);
    pop_expect("foreign_word", 16'hC0DE);
    bus.addr = 16'h0120;
    bus.ior_ = 1'b0;
    #1;
    check("other_rd_z", 32'(data), 32'hFF);
    step();
    bus.ior_ = 1'b1;
    bus.addr = BASE + 16'd1;
    #1;
    check("tsr_addr_no_strobe_z", 32'(data), 32'hFF);
    step();

    // Reset discards a pending high byte
    wr_byte(BASE, 8'h77, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_valid", 32'(bus.out_valid), 32'h0);
    rd_tsr("rst2_tsr", 8'h03);
    wr_word(16'h0102);
    pop_expect("rst2_word", 16'h0102);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
